// File: rtl/bus_responder.sv
// bus_responder: CPU-side bus slave with an internal RAM window at the bottom of the
// address map and a request/acknowledge bridge for all other addresses.
// Optional feature: define WRITE_POST_EN to add a one-deep posted write buffer so the
// CPU does not stall on external writes.
module bus_responder #(
  parameter int unsigned RAM_AW = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] AB,
  input  logic [7:0]  DO,
  input  logic        WE,
  input  logic        sync,
  output logic        rdy,
  output logic [7:0]  DI,
  output logic        ext_req,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_wdata,
  output logic        ext_we,
  output logic        ext_fetch,
  input  logic        ext_ack,
  input  logic [7:0]  ext_rdata
);

  localparam int unsigned RamDepth = 1 << RAM_AW;
  localparam logic [16:0] RamLimit = 17'(RamDepth);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StRdWait = 2'd1;
  localparam logic [1:0] StWrWait = 2'd2;

  logic [7:0]        ram_q [RamDepth];
  logic [RAM_AW-1:0] ram_idx;
  logic              int_hit;
  logic              accept;

  logic [1:0]  state_q, state_d;
  logic [7:0]  di_q, di_d;
  logic [15:0] ext_addr_q, ext_addr_d;
  logic [7:0]  ext_wdata_q, ext_wdata_d;
  logic        ext_we_q, ext_we_d;
  logic        ext_fetch_q, ext_fetch_d;

`ifdef WRITE_POST_EN
  logic        wb_valid_q, wb_valid_d;
`endif

  assign ram_idx = AB[RAM_AW-1:0];
  assign int_hit = {1'b0, AB} < RamLimit;

  // CPU ready: only in IDLE; with posting, external accesses also wait for the buffer
  // to drain so they are issued in program order.
  always_comb begin
`ifdef WRITE_POST_EN
    rdy = (state_q == StIdle) && !(wb_valid_q && !int_hit);
`else
    rdy = (state_q == StIdle);
`endif
  end

  assign accept = rdy && !reset;

  // External request is a pure function of the registered state.
  always_comb begin
`ifdef WRITE_POST_EN
    ext_req = (state_q != StIdle) || wb_valid_q;
`else
    ext_req = (state_q != StIdle);
`endif
  end

  // Next-state logic for the FSM, read data and the external access registers.
  always_comb begin
    state_d     = state_q;
    di_d        = di_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    ext_we_d    = ext_we_q;
    ext_fetch_d = ext_fetch_q;
`ifdef WRITE_POST_EN
    wb_valid_d  = wb_valid_q;
    // The buffer is only ever in flight while the FSM sits in IDLE.
    if (wb_valid_q && ext_ack) begin
      wb_valid_d = 1'b0;
    end
`endif
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (int_hit) begin
            if (!WE) begin
              di_d = ram_q[ram_idx];
            end
          end else begin
            ext_addr_d  = AB;
            ext_wdata_d = DO;
            ext_we_d    = WE;
            ext_fetch_d = sync;
            if (WE) begin
`ifdef WRITE_POST_EN
              wb_valid_d = 1'b1;
`else
              state_d    = StWrWait;
`endif
            end else begin
              state_d = StRdWait;
            end
          end
        end
      end
      StRdWait: begin
        if (ext_ack) begin
          di_d    = ext_rdata;
          state_d = StIdle;
        end
      end
      StWrWait: begin
        if (ext_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      di_q        <= 8'h00;
      ext_addr_q  <= 16'h0000;
      ext_wdata_q <= 8'h00;
      ext_we_q    <= 1'b0;
      ext_fetch_q <= 1'b0;
`ifdef WRITE_POST_EN
      wb_valid_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      di_q        <= di_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
      ext_we_q    <= ext_we_d;
      ext_fetch_q <= ext_fetch_d;
`ifdef WRITE_POST_EN
      wb_valid_q  <= wb_valid_d;
`endif
    end
  end

  // Internal RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && int_hit && WE) begin
      ram_q[ram_idx] <= DO;
    end
  end

  assign DI        = di_q;
  assign ext_addr  = ext_addr_q;
  assign ext_wdata = ext_wdata_q;
  assign ext_we    = ext_we_q;
  assign ext_fetch = ext_fetch_q;

endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 SHALL have parameter RAM_AW, default 9, meaning internal RAM address width; internal region is 0x0000 to 2^RAM_AW-1.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port AB  input  16  CPU address.
REQ-005 SHALL have port DO  input  8  CPU write data.
REQ-006 SHALL have port WE  input  1  CPU write enable (1 = write).
REQ-007 SHALL have port sync  input  1  CPU opcode-fetch marker.
REQ-008 SHALL have port rdy  output  1  CPU ready; 0 stalls the core.
REQ-009 SHALL have port DI  output  8  CPU read data (registered).
REQ-010 SHALL have port ext_req  output  1  external access request.
REQ-011 SHALL have port ext_addr  output  16  external address.
REQ-012 SHALL have port ext_wdata  output  8  external write data.
REQ-013 SHALL have port ext_we  output  1  external write flag.
REQ-014 SHALL have port ext_fetch  output  1  registered copy of sync for the access in flight.
REQ-015 SHALL have port ext_ack  input  1  external completion strobe, one cycle.
REQ-016 SHALL have port ext_rdata  input  8  external read data, valid with ext_ack.

Function
REQ-017 SHALL accept a CPU access at a rising edge when rdy=1 and reset=0; no access is accepted when rdy=0.
REQ-018 SHALL treat AB < 2^RAM_AW as an internal hit and all other addresses as external.
REQ-019 Internal write SHALL update ram[AB] with DO at the accept edge; rdy stays 1.
REQ-020 Internal read SHALL load DI with ram[AB] at the accept edge (1-cycle latency); rdy stays 1.
REQ-021 SHALL implement FSM states IDLE, RD_WAIT and WR_WAIT; rdy SHALL be 0 in every state except IDLE.
REQ-022 External read accept SHALL capture AB, WE and sync into ext_addr, ext_we and ext_fetch, and move IDLE->RD_WAIT.
REQ-023 External write accept without posting SHALL capture AB, DO, WE and sync, and move IDLE->WR_WAIT.
REQ-024 ext_req SHALL be 1 in RD_WAIT and WR_WAIT; ext_addr, ext_wdata, ext_we and ext_fetch SHALL stay stable while ext_req=1.
REQ-025 When ext_ack=1 is sampled in RD_WAIT, DI SHALL load ext_rdata and the FSM SHALL return to IDLE.
REQ-026 When ext_ack=1 is sampled in WR_WAIT, the FSM SHALL return to IDLE.
REQ-027 ext_req SHALL drop in the cycle after the ack edge; minimum external stall is 1 rdy-low cycle.
REQ-028 ext_ack SHALL be ignored while ext_req=0.
REQ-029 DI SHALL hold its value between reads, including through writes and stalls.

Reset
REQ-030 On reset the FSM SHALL enter IDLE with rdy=1, ext_req=0, ext_we=0, ext_fetch=0, DI=0x00 and ext_addr=0x0000.
REQ-031 Reset asserted mid-transaction SHALL abort it at that edge: ext_req=0 next cycle and any posted write discarded.
REQ-032 RAM contents SHALL NOT be reset.

Configuration
REQ-033 Macro WRITE_POST_EN SHALL add a one-deep posted write buffer.
REQ-034 With WRITE_POST_EN, an external write SHALL load the buffer (wb_valid=1) and stay in IDLE with rdy=1, and the buffer SHALL drive ext_req with ext_we=1 until ack, which clears wb_valid.
REQ-035 With WRITE_POST_EN, rdy SHALL be 0 while wb_valid=1 and AB is external, so internal accesses proceed and external reads/writes wait; this preserves ordering.
REQ-036 Without WRITE_POST_EN, external writes SHALL use WR_WAIT and no buffer logic SHALL exist.

Verification
REQ-037 Internal write 0x0042<=0x5A, then read 0x0042 -> DI=0x5A one cycle after the accept, rdy never 0.
REQ-038 External read 0x8000, ext_ack after 3 req cycles with ext_rdata=0xC3 -> rdy low 3 cycles, DI=0xC3, ext_req drops next cycle.
REQ-039 Opcode fetch from 0xFFFC with sync=1 -> ext_fetch=1 for the whole request and ext_we=0.
REQ-040 WRITE_POST_EN: write 0x9000<=0x11, then internal read 0x0010 then read 0x9000 -> first two accesses without stall; read stalls until the write is acked, then issues ext_addr=0x9000 with ext_we=0.
REQ-041 Without WRITE_POST_EN: write 0x9000<=0x11 -> rdy=0 until ack, and ext_wdata=0x11 with ext_we=1 throughout.
REQ-042 Reset during RD_WAIT -> next cycle ext_req=0, rdy=1, DI=0x00, and a late ext_ack is ignored.
